logic_pipe_reg: RTL and testbench



---
 rtl/logic_pipe_reg.sv | 110 +++++++++++
 tb/tb_logic_pipe_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_reg.sv
// Bitwise-function (AND/OR/XOR/NAND) valid/ready pipeline with a delivered-result counter.
// Define LOGIC_PIPE_ZERO_FLAG_EN to add a registered all-zero flag travelling with the result.
module logic_pipe_reg #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES:0]   rdy;
    logic [WIDTH-1:0]  f;
    logic              chain;

    always_comb begin
        f = '0;
        case (op)
            2'd0: f = a & b;
            2'd1: f = a | b;
            2'd2: f = a ^ b;
            2'd3: f = ~(a & b);
        endcase
    end

    // A stage can move when it is empty or everything downstream can move.
    always_comb begin
        rdy         = '0;
        chain       = out_ready;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = ~v[k] | chain;
            rdy[k] = chain;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign c         = d[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= f;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    logic [STAGES-1:0] zf;

    // Flag follows exactly the same load enables as d so it never disagrees with c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= '1;
        end else begin
            if (rdy[0] && in_valid) begin
                zf[0] <= ~|f;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k] && v[k-1]) begin
                    zf[k] <= zf[k-1];
                end
            end
        end
    end

    assign zero = zf[STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_pipe_reg.sv
// Scoreboard bench for logic_pipe_reg: accepted beats are queued with a reference result,
// and an independent output monitor checks order, value, latency, counter and ready.
module tb_logic_pipe_reg;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  c;
    logic [CW-1:0] done_cnt;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    logic          zero;
`endif

    logic_pipe_reg #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c),
        .done_cnt (done_cnt)
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        int           acc;
    } beat_t;

    beat_t sb[$];
    int    checks    = 0;
    int    errors    = 0;
    int    cyc       = 0;
    int    modelCnt  = 0;
    int    lastLow   = 0;
    logic  prevValid = 1'b0;
    logic  prevReady = 1'b1;

    function automatic logic [W-1:0] refOp(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] o);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (o)
                2'd0: r[i] = x[i] && y[i];
                2'd1: r[i] = x[i] || y[i];
                2'd2: r[i] = x[i] != y[i];
                default: r[i] = !(x[i] && y[i]);
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [1:0] o, input logic ordy);
        in_valid  = iv;
        a         = av;
        b         = bv;
        op        = o;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Producer side: record every beat the DUT will take on the coming edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && in_valid && in_ready) begin
            sb.push_back('{val: refOp(a, b, op), acc: cyc});
        end
    end

    // Consumer side: compare what the DUT presents against the queued expectations.
    always @(negedge clk) begin
        int    occ;
        beat_t exp;
        if (rst_n) begin
            occ = sb.size();
            checkOutput("done_cnt", 32'(done_cnt), 32'(modelCnt % (1 << CW)));
            checkOutput("in_ready", 32'(in_ready), 32'((occ < S) || out_ready));
            if (occ == 0) checkOutput("out_valid_empty", 32'(out_valid), 32'd0);
            if (occ == S) checkOutput("out_valid_full", 32'(out_valid), 32'd1);
            if (out_valid && !(prevValid && !prevReady) && occ > 0) begin
                if (lastLow <= sb[0].acc)
                    checkOutput("latency", 32'(cyc - sb[0].acc), 32'(S));
                else
                    checkOutput("latency_min", 32'(cyc - sb[0].acc >= S), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (occ == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_output: got c=%0h, expected no beat", c);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("c", 32'(c), 32'(exp.val));
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
                    checkOutput("zero", 32'(zero), 32'(exp.val == '0));
`endif
                    modelCnt++;
                end
            end
            if (!out_ready) lastLow = cyc;
            prevValid = out_valid;
            prevReady = out_ready;
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_c"}, 32'(c), 32'd0);
        checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        checkOutput({tag, "_zero"}, 32'(zero), 32'd1);
`endif
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b0;
        #12;
        checkResetState("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

        $display("[TB] ops back to back");
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'hF0, 8'h3C, 2'(k), 1'b1);
        repeat (4) applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);

        $display("[TB] backpressure");
        repeat (3) applyStimulus(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_accepted", 32'(sb.size()), 32'(S));
        checkOutput("bp_hold_c", 32'(c), 32'(sb[0].val));
        repeat (4) applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);

        $display("[TB] bubble collapse");
        applyStimulus(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        #1;
        checkOutput("bubble_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();

        $display("[TB] full pipe pass-through");
        repeat (S) applyStimulus(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            a         = W'($urandom);
            b         = W'($urandom);
            op        = 2'($urandom);
            #1;
            checkOutput("pass_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        drain();

        $display("[TB] random traffic");
        repeat (300) applyStimulus(1'($urandom), W'($urandom), W'($urandom), 2'($urandom),
                                   ($urandom_range(0, 3) != 0));

        $display("[TB] async reset mid-stream");
        repeat (S) applyStimulus(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b0);
        #1;
        rst_n = 1'b0;
        sb.delete();
        modelCnt  = 0;
        prevValid = 1'b0;
        prevReady = 1'b1;
        #1;
        checkResetState("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_after_midreset", 32'(in_ready), 32'd1);

        $display("[TB] zero result");
        applyStimulus(1'b1, 8'h0F, 8'hF0, 2'd0, 1'b1);
        repeat (20) applyStimulus(1'($urandom), W'($urandom), W'($urandom), 2'($urandom), 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
